keypad_scan: RTL
================

// Module: keypad_scan
// PURPOSE
//   Scans a 4x4 matrix keypad and debounces it.
//   Produces the keypad event stream consumed by the calculator compute block:
//   one-cycle flag pulse + 4-bit press_num per debounced key press.
//   Sits between the board keypad pins and the compute/display path.
//   Code map: 0-9 digits, 10 '+', 11 '-', 12 '*', 13 '/', 14 clear, 15 '='.
// PARAMETERS
//   CLK_HZ       50_000_000  system clock frequency
//   SCAN_HZ      1000        row-step rate; SCAN_TICKS = CLK_HZ/SCAN_HZ cycles per row
//   DEBOUNCE_MS  20          stable time; DEB_TICKS = (CLK_HZ/1000)*DEBOUNCE_MS cycles
// PORTS
//   clk        in   1  system clock, all logic on posedge
//   rst        in   1  asynchronous, active-high reset
//   key_col    in   4  column sense lines; pulled up, low = key closed (asynchronous)
//   key_row    out  4  row drive, active-low one-hot
//   flag       out  1  one-cycle pulse: new debounced key press
//   press_num  out  4  key code; valid when flag=1, held until next press
//   key_held   out  1  high from the flag cycle until release debounce completes
// BEHAVIOUR
//   Reset values:
//     key_row=4'b1110, flag=0, press_num=0, key_held=0.
//     State SCAN, all counters 0, synchronizer flops = 4'b1111.
//   Input sync: key_col passes a 2-flop synchronizer (col_s).
//     All decisions use col_s; raw key_col is never used.
//   Active row: r = index of the low bit of key_row. Active column: c = index of the low bit of col_s.
//   Key map, row r / col c:
//     r0: 1 2 3 10
//     r1: 4 5 6 11
//     r2: 7 8 9 12
//     r3: 14 0 15 13
//   State SCAN:
//     - Row counter counts 0..SCAN_TICKS-1. At the terminal count, key_row rotates left
//       (1110->1101->1011->0111->1110), counter clears.
//     - If col_s != 4'b1111 in any cycle: latch snap=col_s, freeze key_row,
//       clear the debounce counter, go to DEB_PRESS.
//   State DEB_PRESS:
//     - col_s==snap: counter increments.
//     - col_s!=snap: back to SCAN, same row, row counter cleared. Bounce = no event.
//     - Counter reaches DEB_TICKS-1 with col_s==snap:
//         * snap has exactly one low bit: next cycle flag=1, press_num=map(r,c),
//           key_held=1, go to HELD.
//         * snap has more than one low bit (multi-key in row): no flag, go to HELD.
//   State HELD:
//     - key_row frozen, no further flags, auto-repeat not supported.
//     - col_s==4'b1111: clear counter, go to DEB_REL.
//   State DEB_REL:
//     - col_s==4'b1111: counter increments.
//     - Any low column: counter clears, back to HELD.
//     - Counter reaches DEB_TICKS-1: key_held=0, go to SCAN, rotate to the next row.
//   flag:
//     - Exactly one cycle per accepted press, never two consecutive cycles.
//     - Latency = DEB_TICKS+1 cycles after snap is latched; 2-cycle sync delay comes first.
//   Keys in other rows pressed while one row is frozen are ignored until SCAN resumes.
//   Counters are sized by $clog2 of their tick parameter. No wrap while frozen.
//   rst mid-operation: immediate return to reset values. A pending press is discarded.
//     A key still held after reset is detected afresh from SCAN.
// TESTING  (bench params: CLK_HZ=1000, SCAN_HZ=100, DEBOUNCE_MS=5 -> SCAN_TICKS=10, DEB_TICKS=5)
//   1. Reset, no keys: key_row steps 1110,1101,1011,0111 every 10 cycles; flag never 1.
//   2. Hold r1/c2 ('6') cleanly 100 cycles:
//      exactly one flag with press_num=6, key_held=1.
//      key_held falls 5 cycles after col_s returns to 1111.
//   3. Bounce r0/c3 ('+') low 3 cycles / high 2 cycles x4, then stable 20 cycles:
//      exactly one flag, press_num=10, asserted only after the stable run.
//   4. Press r3/c0 and r3/c1 together: no flag; key_held stays 0; scan resumes after release.
//   5. Press r3/c2 ('='), assert rst mid-DEB_PRESS:
//      outputs go to reset values immediately, no flag.
//      Key still held after rst falls -> one flag, press_num=15.
//   6. Sequence 1,2,+,3,= with clean presses: flag pulses carry 1,2,10,3,15 in order.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: row-scanning 4x4 matrix keypad reader with press and release
// debounce. Emits a one-cycle flag with a 4-bit key code per debounced press.
// Handshake: flag is a single-cycle valid with no ready; press_num is
// qualified by flag and holds its value until the next accepted press.
module keypad_scan #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic       flag,
    output logic [3:0] press_num,
    output logic       key_held
);

    localparam int SCAN_TICKS = CLK_HZ / SCAN_HZ;
    localparam int DEB_TICKS  = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int SCAN_W     = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int DEB_W      = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_TICKS - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_TICKS - 1);

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    // Kept as a plainly named register so checkers can bind to it.
    state_t            state;
    logic [3:0]        col_m;
    logic [3:0]        col_s;
    logic [3:0]        snap;
    logic [SCAN_W-1:0] row_cnt;
    logic [DEB_W-1:0]  deb_cnt;

    // Translate the active row and the single low column into a key code.
    function automatic logic [3:0] key_code(input logic [3:0] row, input logic [3:0] col);
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] code;
        r = 2'd3;
        c = 2'd3;
        code = 4'd0;
        case (row)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            default: r = 2'd3;
        endcase
        case (col)
            4'b1110: c = 2'd0;
            4'b1101: c = 2'd1;
            4'b1011: c = 2'd2;
            default: c = 2'd3;
        endcase
        case ({r, c})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = 4'd10;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = 4'd11;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = 4'd12;
            4'hC: code = 4'd14;
            4'hD: code = 4'd0;
            4'hE: code = 4'd15;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer; the raw column pins are used nowhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_m <= 4'b1111;
            col_s <= 4'b1111;
        end else begin
            col_m <= key_col;
            col_s <= col_m;
        end
    end

    // Scan / debounce FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            key_row   <= 4'b1110;
            flag      <= 1'b0;
            press_num <= 4'd0;
            key_held  <= 1'b0;
            snap      <= 4'b1111;
            row_cnt   <= '0;
            deb_cnt   <= '0;
        end else begin
            flag <= 1'b0;
            case (state)
                SCAN: begin
                    if (col_s != 4'b1111) begin
                        // Freeze on the current row; the row counter simply stops.
                        snap    <= col_s;
                        deb_cnt <= '0;
                        state   <= DEB_PRESS;
                    end else if (row_cnt == SCAN_LAST) begin
                        row_cnt <= '0;
                        key_row <= {key_row[2:0], key_row[3]};
                    end else begin
                        row_cnt <= row_cnt + SCAN_W'(1);
                    end
                end
                DEB_PRESS: begin
                    if (col_s != snap) begin
                        // Bounce: rescan the same row from the start of its slot.
                        row_cnt <= '0;
                        state   <= SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        // Multi-key chords in one row are swallowed silently.
                        if ($onehot(~snap)) begin
                            flag      <= 1'b1;
                            press_num <= key_code(key_row, snap);
                            key_held  <= 1'b1;
                        end
                        state <= HELD;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                HELD: begin
                    if (col_s == 4'b1111) begin
                        deb_cnt <= '0;
                        state   <= DEB_REL;
                    end
                end
                default: begin // DEB_REL
                    if (col_s != 4'b1111) begin
                        deb_cnt <= '0;
                        state   <= HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_held <= 1'b0;
                        row_cnt  <= '0;
                        key_row  <= {key_row[2:0], key_row[3]};
                        state    <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
